// File: rtl/clk_div_pkg.sv
// Shared constants, lock-state encoding and sizing helper for the clk_div_gen slice.
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Index width for n items; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// Ratio-update bus: requester drives valid/ch/div, divider answers ready/err.
interface clk_div_gen_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
) ();

  localparam int CH_W = clk_div_pkg::ch_w(NUM_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: free-running counter, live ratio swapped only at a wrap,
// and registered clock-enable / square-wave outputs.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             apply_req,
  input  logic [DIV_W-1:0] apply_div,
  output logic             apply,
  output logic             ce,
  output logic             clk_out
);

  logic [DIV_W-1:0] cnt_p0;
  logic [DIV_W-1:0] div_p0;
  logic [DIV_W-1:0] last_p0;
  logic [DIV_W-1:0] half_p0;
  logic             at_end_p0;
  logic             wrap_p0;
  logic             ce_p1;
  logic             clk_out_p1;

  // div_p0 never drops below DIV_MIN, so div-1 cannot underflow.
  assign last_p0   = div_p0 - DIV_W'(1);
  assign half_p0   = div_p0 >> 1;
  assign at_end_p0 = (cnt_p0 == last_p0);

  // A disabled channel sits at a permanent wrap point, so a pending ratio lands at once.
  assign wrap_p0 = !en || sync || at_end_p0;
  assign apply   = apply_req && wrap_p0;

  // p0 -> p1: counter and ratio update, outputs decoded from the pre-edge count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0     <= '0;
      div_p0     <= DIV_W'(DEFAULT_DIV);
      ce_p1      <= 1'b0;
      clk_out_p1 <= 1'b0;
    end else begin
      if (apply) begin
        div_p0 <= apply_div;
      end
      if (wrap_p0) begin
        cnt_p0 <= '0;
      end else begin
        cnt_p0 <= cnt_p0 + DIV_W'(1);
      end
      ce_p1      <= en && at_end_p0;
      clk_out_p1 <= en && (cnt_p0 < half_p0);
    end
  end

  assign ce      = ce_p1;
  assign clk_out = clk_out_p1;

endmodule

// File: rtl/clk_div_gen.sv
// N-channel programmable clock-enable generator: single pending ratio slot,
// per-channel dividers and a lock/settle status FSM.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_req,
  clk_div_gen_if.slave      cfg,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int CH_W   = ch_w(NUM_CH);
  localparam int LCNT_W = ch_w(LOCK_CYCLES);

  // Ratios below DIV_MIN would stall the counter; clamp them up.
  function automatic logic [DIV_W-1:0] sat_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : d;
  endfunction

  logic              accept;
  logic              ch_ok;
  logic              slot_vld_p0;
  logic [CH_W-1:0]   slot_ch_p0;
  logic [DIV_W-1:0]  slot_div_p0;
  logic              err_p0;
  logic [NUM_CH-1:0] apply;
  logic              any_apply;
  lock_state_t       lock_st;
  logic [LCNT_W-1:0] lock_cnt;

  assign accept    = cfg.cfg_valid && cfg.cfg_ready;
  assign ch_ok     = (32'(cfg.cfg_ch) < 32'(NUM_CH));
  assign any_apply = |apply;

  // Out-of-range targets are swallowed without occupying the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_p0 <= 1'b0;
      err_p0      <= 1'b0;
    end else begin
      err_p0 <= accept && ch_ok && (cfg.cfg_div < DIV_W'(DIV_MIN));
      if (accept && ch_ok) begin
        slot_vld_p0 <= 1'b1;
      end else if (any_apply) begin
        slot_vld_p0 <= 1'b0;
      end
    end
  end

  // cfg -> p0: slot payload, qualified by slot_vld_p0
  always_ff @(posedge clk) begin
    if (accept && ch_ok) begin
      slot_ch_p0  <= cfg.cfg_ch;
      slot_div_p0 <= sat_div(cfg.cfg_div);
    end
  end

  assign cfg.cfg_ready = !slot_vld_p0;
  assign cfg.cfg_err   = err_p0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (ch_en[i]),
      .sync      (sync_req),
      .apply_req (slot_vld_p0 && (slot_ch_p0 == CH_W'(i))),
      .apply_div (slot_div_p0),
      .apply     (apply[i]),
      .ce        (ce[i]),
      .clk_out   (clk_out[i])
    );
  end

  // Any ratio change or realignment restarts the settle window, even on its last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_st  <= SETTLE;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (any_apply || sync_req) begin
      lock_st  <= SETTLE;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      case (lock_st)
        SETTLE: begin
          if (lock_cnt == LCNT_W'(LOCK_CYCLES - 1)) begin
            lock_st <= LOCKED;
            locked  <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + LCNT_W'(1);
          end
        end
        LOCKED: begin
          locked <= 1'b1;
        end
        default: begin
          lock_st  <= SETTLE;
          lock_cnt <= '0;
          locked   <= 1'b0;
        end
      endcase
    end
  end

endmodule
